// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage -- single-entry instruction decode stage.
//
// Holds one instruction from fetch, decodes its format and immediate, and
// presents register operands read from an external regfile with a 1-cycle
// synchronous read.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   if_valid/if_ready     fetch-side handshake
//   if_pc, if_instr       offered PC and 32-bit instruction
//   flush                 discard held and incoming instruction
//   rs1_addr, rs2_addr    regfile read addresses
//   rs1_rdata, rs2_rdata  regfile read data (one cycle after address)
//   id_valid/id_ready     downstream handshake
//   id_pc, id_instr       held PC and instruction
//   id_rd                 destination register field
//   id_rs1_val/rs2_val    operands (zero for x0)
//   id_imm                sign-extended immediate
//   id_fmt                R=0 I=1 S=2 B=3 U=4 J=5 illegal=7
//   id_illegal            unsupported encoding
// ---------------------------------------------------------------------------
module id_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [XLEN-1:0]   if_pc,
    input  logic [31:0]       if_instr,
    input  logic              flush,
    output logic [REG_AW-1:0] rs1_addr,
    output logic [REG_AW-1:0] rs2_addr,
    input  logic [XLEN-1:0]   rs1_rdata,
    input  logic [XLEN-1:0]   rs2_rdata,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [XLEN-1:0]   id_pc,
    output logic [31:0]       id_instr,
    output logic [REG_AW-1:0] id_rd,
    output logic [XLEN-1:0]   id_rs1_val,
    output logic [XLEN-1:0]   id_rs2_val,
    output logic [XLEN-1:0]   id_imm,
    output logic [2:0]        id_fmt,
    output logic              id_illegal
);

    typedef enum logic {EMPTY, FULL} state_t;

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    state_t state, state_next;
    logic   accept;
    logic   load;

    assign id_valid = (state == FULL);
    assign if_ready = !id_valid || id_ready;
    assign accept   = if_valid && if_ready;
    assign load     = accept && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= EMPTY;
            id_pc    <= '0;
            id_instr <= 32'h0000_0013;
        end else begin
            state <= state_next;
            if (load) begin
                id_pc    <= if_pc;
                id_instr <= if_instr;
            end
        end
    end

    // Flush wins over both accept and drain.
    always_comb begin
        state_next = state;
        if (flush)
            state_next = EMPTY;
        else if (accept)
            state_next = FULL;
        else if (id_valid && id_ready)
            state_next = EMPTY;
    end

    // Address follows the incoming instruction only when it is being taken,
    // so the regfile output keeps tracking the held instruction while stalled.
    always_comb begin
        if (accept) begin
            rs1_addr = REG_AW'(if_instr[19:15]);
            rs2_addr = REG_AW'(if_instr[24:20]);
        end else begin
            rs1_addr = REG_AW'(id_instr[19:15]);
            rs2_addr = REG_AW'(id_instr[24:20]);
        end
    end

    assign id_rs1_val = (id_instr[19:15] == 5'd0) ? '0 : rs1_rdata;
    assign id_rs2_val = (id_instr[24:20] == 5'd0) ? '0 : rs2_rdata;
    assign id_rd      = REG_AW'(id_instr[11:7]);

    always_comb begin
        id_fmt = FMT_ILL;
        unique case (id_instr[6:0])
            7'b0110111, 7'b0010111:                                     id_fmt = FMT_U;
            7'b1101111:                                                 id_fmt = FMT_J;
            7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011, 7'b0001111: id_fmt = FMT_I;
            7'b0100011:                                                 id_fmt = FMT_S;
            7'b1100011:                                                 id_fmt = FMT_B;
            7'b0110011:                                                 id_fmt = FMT_R;
            default:                                                    id_fmt = FMT_ILL;
        endcase
    end

    assign id_illegal = (id_fmt == FMT_ILL);

    logic [31:0]            imm32;
    logic signed [XLEN-1:0] imm_ext;

    always_comb begin
        imm32 = '0;
        case (id_fmt)
            FMT_I: imm32 = {{20{id_instr[31]}}, id_instr[31:20]};
            FMT_S: imm32 = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
            FMT_B: imm32 = {{19{id_instr[31]}}, id_instr[31], id_instr[7],
                            id_instr[30:25], id_instr[11:8], 1'b0};
            FMT_U: imm32 = {id_instr[31:12], 12'b0};
            FMT_J: imm32 = {{11{id_instr[31]}}, id_instr[31], id_instr[19:12],
                            id_instr[20], id_instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        imm_ext = $signed(imm32);
    end

    assign id_imm = imm_ext;

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        flush;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_rdata, rs2_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc, id_instr;
    logic [4:0]  id_rd;
    logic [31:0] id_rs1_val, id_rs2_val, id_imm;
    logic [2:0]  id_fmt;
    logic        id_illegal;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
        .flush(flush),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr),
        .id_rd(id_rd), .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val),
        .id_imm(id_imm), .id_fmt(id_fmt), .id_illegal(id_illegal)
    );

    // Regfile model: synchronous read, write-through, x0 not hardwired so the
    // stage itself must zero x0 operands.
    logic        rf_we = 1'b0;
    logic [4:0]  rf_waddr = '0;
    logic [31:0] rf_wdata = '0;
    logic [31:0] regs [32];

    always @(posedge clk) begin
        if (rf_we) regs[rf_waddr] <= rf_wdata;
        rs1_rdata <= (rf_we && rf_waddr == rs1_addr) ? rf_wdata : regs[rs1_addr];
        rs2_rdata <= (rf_we && rf_waddr == rs2_addr) ? rf_wdata : regs[rs2_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
        rf_we = 1'b1; rf_waddr = a; rf_wdata = d;
        tick();
        rf_we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_valid = 1'b1; if_pc = 32'h0000_0040; if_instr = 32'h0020_81B3;
        flush = 1'b1; id_ready = 1'b0;
        tick();
        #1;
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", id_valid); end
        checks++; if (id_instr !== 32'h0000_0013) begin failures++; $display("FAIL rst_instr got=%h exp=00000013", id_instr); end
        checks++; if (id_pc !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=0", id_pc); end
        checks++; if (id_rd !== 5'd0) begin failures++; $display("FAIL rst_rd got=%0d exp=0", id_rd); end
        checks++; if (id_fmt !== 3'd1) begin failures++; $display("FAIL rst_fmt got=%0d exp=1", id_fmt); end
        checks++; if (id_imm !== 32'h0) begin failures++; $display("FAIL rst_imm got=%h exp=0", id_imm); end
        checks++; if (id_illegal !== 1'b0) begin failures++; $display("FAIL rst_illegal got=%0h exp=0", id_illegal); end
        rst_n = 1'b1; if_valid = 1'b0; flush = 1'b0;
        #1;
        checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL rst_if_ready got=%0h exp=1", if_ready); end
    endtask

    task automatic test_accept();
        rf_write(5'd5, 32'h0000_1234);
        id_ready = 1'b1; if_valid = 1'b1; if_pc = 32'h0000_0100; if_instr = 32'hFFF2_8393;
        #1;
        checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL acc_if_ready got=%0h exp=1", if_ready); end
        checks++; if (rs1_addr !== 5'd5) begin failures++; $display("FAIL acc_rs1_addr got=%0d exp=5", rs1_addr); end
        tick();
        if_valid = 1'b0;
        #1;
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL acc_valid got=%0h exp=1", id_valid); end
        checks++; if (id_pc !== 32'h100) begin failures++; $display("FAIL acc_pc got=%h exp=00000100", id_pc); end
        checks++; if (id_rd !== 5'd7) begin failures++; $display("FAIL acc_rd got=%0d exp=7", id_rd); end
        checks++; if (id_rs1_val !== 32'h1234) begin failures++; $display("FAIL acc_rs1_val got=%h exp=00001234", id_rs1_val); end
        checks++; if (id_imm !== 32'hFFFF_FFFF) begin failures++; $display("FAIL acc_imm got=%h exp=ffffffff", id_imm); end
        checks++; if (id_fmt !== 3'd1) begin failures++; $display("FAIL acc_fmt got=%0d exp=1", id_fmt); end
    endtask

    task automatic test_stall();
        id_ready = 1'b0; if_valid = 1'b1; if_pc = 32'h0000_0104; if_instr = 32'h0020_81B3;
        #1;
        checks++; if (if_ready !== 1'b0) begin failures++; $display("FAIL stall_if_ready got=%0h exp=0", if_ready); end
        checks++; if (rs1_addr !== 5'd5) begin failures++; $display("FAIL stall_rs1_addr got=%0d exp=5", rs1_addr); end
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin rf_we = 1'b1; rf_waddr = 5'd5; rf_wdata = 32'h55; end
            tick();
            rf_we = 1'b0;
            #1;
            checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d] got=%0h exp=1", i, id_valid); end
            checks++; if (id_pc !== 32'h100) begin failures++; $display("FAIL stall_pc[%0d] got=%h exp=00000100", i, id_pc); end
            checks++; if (id_instr !== 32'hFFF2_8393) begin failures++; $display("FAIL stall_instr[%0d] got=%h exp=fff28393", i, id_instr); end
            checks++; if (id_imm !== 32'hFFFF_FFFF) begin failures++; $display("FAIL stall_imm[%0d] got=%h exp=ffffffff", i, id_imm); end
            checks++; if (if_ready !== 1'b0) begin failures++; $display("FAIL stall_if_ready[%0d] got=%0h exp=0", i, if_ready); end
            checks++;
            if (id_rs1_val !== ((i >= 1) ? 32'h55 : 32'h1234)) begin
                failures++; $display("FAIL stall_rs1_val[%0d] got=%h exp=%h", i, id_rs1_val, (i >= 1) ? 32'h55 : 32'h1234);
            end
        end
        id_ready = 1'b1;
        #1;
        checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL unstall_if_ready got=%0h exp=1", if_ready); end
        tick();
        if_valid = 1'b0;
        #1;
        checks++; if (id_pc !== 32'h104) begin failures++; $display("FAIL unstall_pc got=%h exp=00000104", id_pc); end
        checks++; if (id_instr !== 32'h0020_81B3) begin failures++; $display("FAIL unstall_instr got=%h exp=002081b3", id_instr); end
        checks++; if (id_fmt !== 3'd0) begin failures++; $display("FAIL unstall_fmt got=%0d exp=0", id_fmt); end
        checks++; if (id_rd !== 5'd3) begin failures++; $display("FAIL unstall_rd got=%0d exp=3", id_rd); end
        checks++; if (id_imm !== 32'h0) begin failures++; $display("FAIL unstall_imm got=%h exp=0", id_imm); end
    endtask

    task automatic test_back_to_back();
        rf_write(5'd0, 32'hDEAD_BEEF);
        id_ready = 1'b1; if_valid = 1'b1; if_pc = 32'h200; if_instr = 32'hFE00_0EE3; // beq x0,x0,-4
        tick();
        if_pc = 32'h204; if_instr = 32'h0010_00EF;                                  // jal x1,+2048
        #1;
        checks++; if (id_rs1_val !== 32'h0) begin failures++; $display("FAIL beq_rs1_val got=%h exp=0", id_rs1_val); end
        checks++; if (id_rs2_val !== 32'h0) begin failures++; $display("FAIL beq_rs2_val got=%h exp=0", id_rs2_val); end
        checks++; if (id_imm !== 32'hFFFF_FFFC) begin failures++; $display("FAIL beq_imm got=%h exp=fffffffc", id_imm); end
        checks++; if (id_fmt !== 3'd3) begin failures++; $display("FAIL beq_fmt got=%0d exp=3", id_fmt); end
        tick();
        if_pc = 32'h208; if_instr = 32'h1234_5537;                                  // lui x10,0x12345
        #1;
        checks++; if (id_pc !== 32'h204) begin failures++; $display("FAIL jal_pc got=%h exp=00000204", id_pc); end
        checks++; if (id_imm !== 32'h800) begin failures++; $display("FAIL jal_imm got=%h exp=00000800", id_imm); end
        checks++; if (id_fmt !== 3'd5) begin failures++; $display("FAIL jal_fmt got=%0d exp=5", id_fmt); end
        checks++; if (id_rd !== 5'd1) begin failures++; $display("FAIL jal_rd got=%0d exp=1", id_rd); end
        tick();
        if_pc = 32'h20C; if_instr = 32'hFE20_AC23;                                  // sw x2,-8(x1)
        #1;
        checks++; if (id_imm !== 32'h1234_5000) begin failures++; $display("FAIL lui_imm got=%h exp=12345000", id_imm); end
        checks++; if (id_fmt !== 3'd4) begin failures++; $display("FAIL lui_fmt got=%0d exp=4", id_fmt); end
        tick();
        if_valid = 1'b0;
        #1;
        checks++; if (id_imm !== 32'hFFFF_FFF8) begin failures++; $display("FAIL sw_imm got=%h exp=fffffff8", id_imm); end
        checks++; if (id_fmt !== 3'd2) begin failures++; $display("FAIL sw_fmt got=%0d exp=2", id_fmt); end
    endtask

    task automatic test_flush();
        flush = 1'b1; id_ready = 1'b1; if_valid = 1'b1; if_pc = 32'h300; if_instr = 32'hFFF2_8393;
        #1;
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL flush_pre_valid got=%0h exp=1", id_valid); end
        checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL flush_if_ready got=%0h exp=1", if_ready); end
        tick();
        flush = 1'b0; if_pc = 32'h304; if_instr = 32'h0020_81B3;
        #1;
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0h exp=0", id_valid); end
        tick();
        if_valid = 1'b0; id_ready = 1'b0;
        #1;
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL post_flush_valid got=%0h exp=1", id_valid); end
        checks++; if (id_pc !== 32'h304) begin failures++; $display("FAIL post_flush_pc got=%h exp=00000304", id_pc); end
        // Flush while stalled discards the held instruction.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL stall_flush_valid got=%0h exp=0", id_valid); end
    endtask

    task automatic test_illegal();
        id_ready = 1'b1; if_valid = 1'b1; if_pc = 32'h400; if_instr = 32'h0000_007F;
        tick();
        if_pc = 32'h404; if_instr = 32'h0000_0001;
        #1;
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL ill7f_valid got=%0h exp=1", id_valid); end
        checks++; if (id_illegal !== 1'b1) begin failures++; $display("FAIL ill7f_illegal got=%0h exp=1", id_illegal); end
        checks++; if (id_fmt !== 3'd7) begin failures++; $display("FAIL ill7f_fmt got=%0d exp=7", id_fmt); end
        checks++; if (id_imm !== 32'h0) begin failures++; $display("FAIL ill7f_imm got=%h exp=0", id_imm); end
        tick();
        if_valid = 1'b0;
        #1;
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL ill01_valid got=%0h exp=1", id_valid); end
        checks++; if (id_illegal !== 1'b1) begin failures++; $display("FAIL ill01_illegal got=%0h exp=1", id_illegal); end
        checks++; if (id_fmt !== 3'd7) begin failures++; $display("FAIL ill01_fmt got=%0d exp=7", id_fmt); end
        checks++; if (id_imm !== 32'h0) begin failures++; $display("FAIL ill01_imm got=%h exp=0", id_imm); end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; if_valid = 1'b0; if_pc = '0; if_instr = '0; flush = 1'b0; id_ready = 1'b0;
        #2;
        test_reset();
        test_accept();
        test_stall();
        test_back_to_back();
        test_flush();
        test_illegal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
